mux8x1_using_2x1: RTL and testbench

MUX8X1_USING_2X1 -- requirements
Module: mux8x1_using_2x1

---
 rtl/mux8x1_pkg.sv | 11 +
 rtl/mux8x1_using_2x1_mux2x1.sv | 18 +
 rtl/mux8x1_using_2x1.sv | 98 +++++++++
 tb/tb_mux8x1_using_2x1.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux8x1_pkg.sv
// mux8x1_pkg: shared constants for the registered 8:1 mux built from 2:1 cells.
// Rev 1.0
`default_nettype none

package mux8x1_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int NUM_INPUTS    = 8;
  localparam int SEL_W         = 3;
endpackage

`default_nettype wire

// File: rtl/mux8x1_using_2x1_mux2x1.sv
// mux2x1: combinational 2:1 selector cell (y = s ? b : a).
// Rev 1.0
`default_nettype none

module mux2x1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? b : a;

endmodule

`default_nettype wire

// File: rtl/mux8x1_using_2x1.sv
// mux8x1_using_2x1: 8:1 mux as a tree of seven mux2x1 cells, output registered on en.
// Optional registered parity output y_par enabled by macro MUX8X1_PARITY_EN. Rev 1.0
`default_nettype none

module mux8x1_using_2x1
  import mux8x1_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  input  logic             s0,
  input  logic             s1,
  input  logic             s2,
  output logic [WIDTH-1:0] y,
  output logic             y_valid
`ifdef MUX8X1_PARITY_EN
  ,
  output logic             y_par
`endif
);

  logic [SEL_W-1:0] sel;
  logic [WIDTH-1:0] data [NUM_INPUTS];
  logic [WIDTH-1:0] lvl1 [4];
  logic [WIDTH-1:0] lvl2 [2];
  logic [WIDTH-1:0] tree_y;

  assign sel     = {s2, s1, s0};
  assign data[0] = i0;
  assign data[1] = i1;
  assign data[2] = i2;
  assign data[3] = i3;
  assign data[4] = i4;
  assign data[5] = i5;
  assign data[6] = i6;
  assign data[7] = i7;

  // Level 1 pairs adjacent inputs on s0; level 2 pairs those on s1; s2 picks the half.
  for (genvar k = 0; k < 4; k++) begin : g_lvl1
    mux2x1 #(.WIDTH(WIDTH)) u_mux (
      .a (data[2*k]),
      .b (data[2*k+1]),
      .s (sel[0]),
      .y (lvl1[k])
    );
  end

  for (genvar k = 0; k < 2; k++) begin : g_lvl2
    mux2x1 #(.WIDTH(WIDTH)) u_mux (
      .a (lvl1[2*k]),
      .b (lvl1[2*k+1]),
      .s (sel[1]),
      .y (lvl2[k])
    );
  end

  mux2x1 #(.WIDTH(WIDTH)) u_lvl3 (
    .a (lvl2[0]),
    .b (lvl2[1]),
    .s (sel[2]),
    .y (tree_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= en;
      if (en) begin
        y <= tree_y;
      end
    end
  end

`ifdef MUX8X1_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (en) begin
      y_par <= ^tree_y;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux8x1_using_2x1.sv
// tb_mux8x1_using_2x1: self-checking bench against an array-indexed reference model.
`default_nettype none

module tb_mux8x1_using_2x1;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         s0, s1, s2;
  logic [W-1:0] din [8];
  logic [W-1:0] y;
  logic         y_valid;
`ifdef MUX8X1_PARITY_EN
  logic         y_par;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mux8x1_using_2x1 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .i0      (din[0]),
    .i1      (din[1]),
    .i2      (din[2]),
    .i3      (din[3]),
    .i4      (din[4]),
    .i5      (din[5]),
    .i6      (din[6]),
    .i7      (din[7]),
    .s0      (s0),
    .s1      (s1),
    .s2      (s2),
    .y       (y),
    .y_valid (y_valid)
`ifdef MUX8X1_PARITY_EN
    ,
    .y_par   (y_par)
`endif
  );

  task automatic drive(input bit e, input int sel);
    @(negedge clk);
    en = e;
    {s2, s1, s0} = sel[2:0];
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    en    = 1'b1;
    {s2, s1, s0} = 3'($urandom_range(7));
    for (int k = 0; k < 8; k++) din[k] = W'($urandom);
    #2;
    checks++;
    if (y !== 4'h0) begin errors++; $display("FAIL reset_y: y=%h expected 0", y); end
    checks++;
    if (y_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: y_valid=%b expected 0", y_valid); end
`ifdef MUX8X1_PARITY_EN
    checks++;
    if (y_par !== 1'b0) begin errors++; $display("FAIL reset_par: y_par=%b expected 0", y_par); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sweep;
    for (int k = 0; k < 8; k++) din[k] = W'(k);
    for (int s = 0; s < 8; s++) begin
      drive(1'b1, s);
      tick();
      checks++;
      if (y !== W'(s) || y_valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep sel=%0d: y=%h valid=%b expected y=%h valid=1", s, y, y_valid, W'(s));
      end
    end
  endtask

  task automatic test_hold;
    for (int k = 0; k < 8; k++) din[k] = W'(k);
    drive(1'b1, 5);
    tick();
    checks++;
    if (y !== 4'h5) begin errors++; $display("FAIL hold_capture: y=%h expected 5", y); end
    drive(1'b0, 2);
    for (int n = 0; n < 2; n++) begin
      tick();
      checks++;
      if (y !== 4'h5 || y_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: y=%h valid=%b expected y=5 valid=0", n, y, y_valid);
      end
    end
  endtask

  task automatic test_bit_independence;
    for (int k = 0; k < 8; k++) din[k] = 4'hF;
    din[3] = 4'hA;
    din[4] = 4'h5;
    drive(1'b1, 3);
    tick();
    checks++;
    if (y !== 4'hA) begin errors++; $display("FAIL bits_sel3: y=%h expected a", y); end
    drive(1'b1, 4);
    tick();
    checks++;
    if (y !== 4'h5) begin errors++; $display("FAIL bits_sel4: y=%h expected 5", y); end
  endtask

`ifdef MUX8X1_PARITY_EN
  task automatic test_parity;
    for (int k = 0; k < 8; k++) din[k] = 4'h0;
    din[6] = 4'h7;
    din[5] = 4'h5;
    drive(1'b1, 6);
    tick();
    checks++;
    if (y !== 4'h7 || y_par !== 1'b1) begin
      errors++; $display("FAIL parity_sel6: y=%h par=%b expected y=7 par=1", y, y_par);
    end
    drive(1'b1, 5);
    tick();
    checks++;
    if (y !== 4'h5 || y_par !== 1'b0) begin
      errors++; $display("FAIL parity_sel5: y=%h par=%b expected y=5 par=0", y, y_par);
    end
    din[6] = 4'h1;
    drive(1'b0, 6);
    tick();
    checks++;
    if (y_par !== 1'b0) begin errors++; $display("FAIL parity_hold: par=%b expected 0", y_par); end
  endtask
`endif

  task automatic test_random;
    logic [W-1:0] exp_y;
    bit           exp_v;
    int           sel;
    for (int k = 0; k < 8; k++) din[k] = W'($urandom);
    drive(1'b1, 0);
    tick();
    exp_y = din[0];
    exp_v = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      for (int k = 0; k < 8; k++) din[k] = W'($urandom);
      sel = int'($urandom_range(7));
      en  = ($urandom_range(3) != 0);
      {s2, s1, s0} = sel[2:0];
      #1;
      checks++;
      if (y !== exp_y) begin
        errors++; $display("FAIL rand_midcycle n=%0d: y=%h expected %h", n, y, exp_y);
      end
      tick();
      if (en) exp_y = din[sel];
      exp_v = en;
      checks++;
      if (y !== exp_y || y_valid !== exp_v) begin
        errors++;
        $display("FAIL rand n=%0d sel=%0d en=%b: y=%h valid=%b expected y=%h valid=%b",
                 n, sel, en, y, y_valid, exp_y, exp_v);
      end
`ifdef MUX8X1_PARITY_EN
      checks++;
      if (y_par !== 1'(($countones(exp_y)) % 2)) begin
        errors++; $display("FAIL rand_par n=%0d: par=%b expected %0d", n, y_par, $countones(exp_y) % 2);
      end
`endif
    end
  endtask

  task automatic test_mid_reset;
    for (int k = 0; k < 8; k++) din[k] = W'(k);
    drive(1'b1, 6);
    tick();
    checks++;
    if (y !== 4'h6) begin errors++; $display("FAIL midrst_pre: y=%h expected 6", y); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 4'h0 || y_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_async: y=%h valid=%b expected y=0 valid=0", y, y_valid);
    end
    tick();
    checks++;
    if (y !== 4'h0 || y_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_held: y=%h valid=%b expected y=0 valid=0", y, y_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b1;
    {s2, s1, s0} = 3'd1;
    tick();
    checks++;
    if (y !== 4'h1 || y_valid !== 1'b1) begin
      errors++; $display("FAIL midrst_release: y=%h valid=%b expected y=1 valid=1", y, y_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_hold();
    test_bit_independence();
`ifdef MUX8X1_PARITY_EN
    test_parity();
`endif
    test_random();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
